// File: rtl/periph_bus_master.sv
// periph_bus_master: turns single commands into phased chip-select/strobe cycles on the peripheral bus.
// Defining PERIPH_BUS_MASTER_POLL_EN builds the poll command (repeat read until masked match).
module periph_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned POLL_MAX   = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic [7:0] cmd_mask,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       bus_cs_n,
  output logic       bus_rd_n,
  output logic       bus_wr_n,
  output logic [3:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
      HOLD_CYC < 1 || HOLD_CYC > 15 || POLL_MAX < 1 || POLL_MAX > 65535) begin : g_bad_param
    $error("periph_bus_master: timing parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_REJECT, S_DONE
  } state_e;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_POLL  = 2'd2;

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [1:0] op_q;
  logic [7:0] rdata_q;
  logic       cmd_ready_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;
  logic       rsp_err_q;
  logic       bus_cs_n_q;
  logic       bus_rd_n_q;
  logic       bus_wr_n_q;
  logic [3:0] bus_addr_q;
  logic [7:0] bus_wdata_q;

  logic       op_supported;
  logic       retry;
  logic       timeout;

`ifdef PERIPH_BUS_MASTER_POLL_EN
  logic [7:0]  expect_q;
  logic [7:0]  mask_q;
  logic [15:0] attempts_q;
  logic [15:0] attempts_d;

  always_comb begin
    op_supported = (cmd_op != 2'd3);
    retry        = (op_q == OP_POLL) && ((rdata_q & mask_q) != (expect_q & mask_q));
    timeout      = retry && (attempts_q == 16'(POLL_MAX));
    attempts_d   = attempts_q + 16'd1;
  end
`else
  always_comb begin
    op_supported = (cmd_op == OP_WRITE) || (cmd_op == OP_READ);
    retry        = 1'b0;
    timeout      = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_WRITE;
      rdata_q     <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      bus_cs_n_q  <= 1'b1;
      bus_rd_n_q  <= 1'b1;
      bus_wr_n_q  <= 1'b1;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
`ifdef PERIPH_BUS_MASTER_POLL_EN
      expect_q    <= '0;
      mask_q      <= '0;
      attempts_q  <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            op_q        <= cmd_op;
`ifdef PERIPH_BUS_MASTER_POLL_EN
            expect_q    <= cmd_wdata;
            mask_q      <= cmd_mask;
            attempts_q  <= '0;
`endif
            if (op_supported) begin
              state_q     <= S_SETUP;
              cnt_q       <= SETUP_LOAD;
              bus_cs_n_q  <= 1'b0;
              bus_addr_q  <= cmd_addr;
              bus_wdata_q <= (cmd_op == OP_WRITE) ? cmd_wdata : 8'h00;
            end else begin
              state_q <= S_REJECT;
            end
          end
        end
        S_SETUP: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_STROBE;
            // Writes are never stretched: slaves count every strobed cycle as a new write.
            if (op_q == OP_WRITE) begin
              bus_wr_n_q <= 1'b0;
              cnt_q      <= 4'd0;
            end else begin
              bus_rd_n_q <= 1'b0;
              cnt_q      <= STROBE_LOAD;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_STROBE: begin
          if (cnt_q == 4'd0) begin
            bus_wr_n_q <= 1'b1;
            bus_rd_n_q <= 1'b1;
            if (op_q != OP_WRITE) begin
              rdata_q <= bus_rdata;
`ifdef PERIPH_BUS_MASTER_POLL_EN
              attempts_q <= attempts_d;
`endif
            end
            state_q <= S_HOLD;
            cnt_q   <= HOLD_LOAD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_HOLD: begin
          if (cnt_q == 4'd0) begin
            bus_cs_n_q  <= 1'b1;
            bus_wdata_q <= '0;
            if (retry && !timeout) begin
              state_q <= S_GAP;
            end else begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= (op_q == OP_WRITE) ? 8'h00 : rdata_q;
              rsp_err_q   <= timeout;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_GAP: begin
          state_q    <= S_SETUP;
          cnt_q      <= SETUP_LOAD;
          bus_cs_n_q <= 1'b0;
        end
        // One idle cycle so rejected ops answer two cycles after accept.
        S_REJECT: begin
          state_q     <= S_DONE;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= 8'h00;
          rsp_err_q   <= 1'b1;
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          bus_cs_n_q  <= 1'b1;
          bus_rd_n_q  <= 1'b1;
          bus_wr_n_q  <= 1'b1;
          bus_wdata_q <= '0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign bus_cs_n  = bus_cs_n_q;
  assign bus_rd_n  = bus_rd_n_q;
  assign bus_wr_n  = bus_wr_n_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Testbench for periph_bus_master: table of commands with a response scoreboard and a bus monitor,
// plus hand-written back-to-back and mid-transaction reset sequences.
module tb_periph_bus_master;

  localparam int S  = 1;
  localparam int ST = 2;
  localparam int H  = 1;
  localparam int PM = 4;

  typedef struct {
    logic [1:0] op;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         lat;
    int         rd_starts;
    int         rd_cycles;
    int         wr_cycles;
    int         cs_low;
    int         cs_periods;
    int         first_cs;
    int         wr_at;
  } exp_t;

  typedef struct {
    logic [1:0]      op;
    logic [3:0]      addr;
    logic [7:0]      wdata;
    logic [7:0]      mask;
    logic [3:0][7:0] sv;
    exp_t            e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic [7:0] cmd_mask = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       bus_cs_n, bus_rd_n, bus_wr_n;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [3:0][7:0] slave_vals = '0;
  int         slave_idx = 0;
  wire [7:0]  bus_rdata = slave_vals[(slave_idx > 3) ? 2'd3 : 2'(slave_idx)];

  always #5 clk = ~clk;

  periph_bus_master #(.SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H), .POLL_MAX(PM)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_cs_n(bus_cs_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  int   vec_count = 0;
  int   miss_count = 0;
  exp_t sb[$];
  vec_t vecs[8];

  task automatic chk(input string nm, input int got, input int req);
    vec_count++;
    if (got != req) begin
      miss_count++;
      $display("FAIL %s got=%0d (0x%0h) required=%0d (0x%0h)", nm, got, got, req, req);
    end
  endtask

  // Expected bus activity derived from the configured phase lengths.
  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] a, input logic [7:0] wd,
                              input logic [7:0] m, input logic [31:0] sv, input int nreads,
                              input logic err, input logic [7:0] rd);
    vec_t v;
    v.op = op; v.addr = a; v.wdata = wd; v.mask = m; v.sv = sv;
    v.e.op = op; v.e.addr = a; v.e.wdata = wd; v.e.rdata = rd; v.e.err = err;
    v.e.rd_starts = 0; v.e.rd_cycles = 0; v.e.wr_cycles = 0; v.e.cs_low = 0;
    v.e.cs_periods = 0; v.e.first_cs = -1; v.e.wr_at = -1;
    if (nreads < 0) begin
      v.e.lat = 2;
    end else if (op == 2'd0) begin
      v.e.lat = S + 1 + H + 1; v.e.wr_cycles = 1; v.e.cs_low = S + 1 + H;
      v.e.cs_periods = 1; v.e.first_cs = 1; v.e.wr_at = S + 1;
    end else begin
      v.e.lat = nreads * (S + ST + H) + (nreads - 1) + 1;
      v.e.rd_starts = nreads; v.e.rd_cycles = nreads * ST; v.e.cs_low = nreads * (S + ST + H);
      v.e.cs_periods = nreads; v.e.first_cs = 1;
    end
    return v;
  endfunction

  // Bus monitor and response checker, sampled mid-cycle.
  int         cyc, rd_starts, rd_cycles, wr_cycles, cs_low, cs_periods, first_cs, wr_at;
  int         bad_proto = 0;
  int         txn = 0;
  bit         busy = 0;
  logic [1:0] cur_op = '0;
  logic [3:0] st_addr, wr_addr;
  logic [7:0] wr_data;
  logic [7:0] last_rdata = '0;
  logic       last_err = 1'b0;
  logic       prev_cs_n = 1'b1, prev_rd_n = 1'b1, prev_wr_n = 1'b1;
  logic [3:0] prev_addr = '0;
  logic [7:0] prev_wdata = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      busy = 0; last_rdata = '0; last_err = 1'b0;
    end else begin
      cyc++;
      if (!bus_cs_n) begin
        cs_low++;
        if (first_cs < 0) first_cs = cyc;
        if (prev_cs_n) cs_periods++;
      end
      if (!bus_wr_n) begin wr_cycles++; wr_at = cyc; wr_addr = bus_addr; wr_data = bus_wdata; end
      if (!bus_rd_n) begin rd_cycles++; st_addr = bus_addr; if (prev_rd_n) rd_starts++; end
      if (!bus_wr_n) st_addr = bus_addr;
      if (bus_rd_n && !prev_rd_n) slave_idx++;
      if ((!bus_rd_n || !bus_wr_n) && bus_cs_n) bad_proto++;
      if (!bus_rd_n && !bus_wr_n) bad_proto++;
      if (bus_wdata != 8'h00 && (bus_cs_n || cur_op != 2'd0)) bad_proto++;
      if ((bus_cs_n != prev_cs_n || bus_addr != prev_addr || bus_wdata != prev_wdata) &&
          !(bus_rd_n && bus_wr_n && prev_rd_n && prev_wr_n)) bad_proto++;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          txn++;
          $display("txn %0d op=%0d addr=%0h rsp_rdata=%02h rsp_err=%0d latency=%0d reads=%0d cs_low=%0d",
                   txn, e.op, e.addr, rsp_rdata, rsp_err, cyc, rd_starts, cs_low);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          chk("latency", cyc, e.lat);
          chk("read_strobes", rd_starts, e.rd_starts);
          chk("rd_n_low_cycles", rd_cycles, e.rd_cycles);
          chk("wr_n_low_cycles", wr_cycles, e.wr_cycles);
          chk("cs_n_low_cycles", cs_low, e.cs_low);
          chk("cs_n_periods", cs_periods, e.cs_periods);
          chk("first_cs_cycle", first_cs, e.first_cs);
          chk("write_strobe_cycle", wr_at, e.wr_at);
          if (e.first_cs > 0) chk("strobe_addr", st_addr, e.addr);
          if (e.wr_at > 0) begin
            chk("write_addr", wr_addr, e.addr);
            chk("write_data", wr_data, e.wdata);
          end
          chk("protocol_violations", bad_proto, 0);
        end
        busy = 0; last_rdata = rsp_rdata; last_err = rsp_err;
      end else if (rsp_rdata != last_rdata || rsp_err != last_err) begin
        bad_proto++;
      end
      if (cmd_valid && cmd_ready) begin
        chk("accept_while_busy", busy, 0);
        busy = 1; cur_op = cmd_op; cyc = 0;
        rd_starts = 0; rd_cycles = 0; wr_cycles = 0; cs_low = 0; cs_periods = 0;
        first_cs = -1; wr_at = -1; slave_idx = 0; st_addr = '0;
      end
    end
    prev_cs_n = bus_cs_n; prev_rd_n = bus_rd_n; prev_wr_n = bus_wr_n;
    prev_addr = bus_addr; prev_wdata = bus_wdata;
  end

  task automatic drive(input vec_t v, input bit hold, input bit expect_rsp);
    int budget;
    @(posedge clk); #1;
    cmd_op = v.op; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_mask = v.mask;
    if (v.op == 2'd1 || v.op == 2'd2) slave_vals = v.sv;
    cmd_valid = 1'b1;
    if (expect_rsp) sb.push_back(v.e);
    budget = 200;
    do begin
      @(negedge clk);
      budget--;
    end while (!cmd_ready && budget > 0);
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      if (expect_rsp) void'(sb.pop_back());
      return;
    end
    @(posedge clk); #1;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_op = 2'd3; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_mask = ~v.mask;
    end
  endtask

  task automatic drain();
    int budget = 600;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() != 0) begin
      chk("response_timeout_pending", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_bus_cs_n"}, bus_cs_n, 1);
    chk({tag, "_bus_rd_n"}, bus_rd_n, 1);
    chk({tag, "_bus_wr_n"}, bus_wr_n, 1);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_wdata"}, bus_wdata, 0);
  endtask

  initial begin
    int budget;
    vecs[0] = mk(2'd0, 4'h1, 8'h5A, 8'h00, 32'h0,         0, 1'b0, 8'h00);
    vecs[1] = mk(2'd1, 4'h5, 8'h00, 8'h00, 32'h01010101,  1, 1'b0, 8'h01);
`ifdef PERIPH_BUS_MASTER_POLL_EN
    vecs[2] = mk(2'd2, 4'h5, 8'h00, 8'h01, 32'h00010101,  4, 1'b0, 8'h00);
    vecs[3] = mk(2'd2, 4'h5, 8'h00, 8'hFF, 32'hFFFFFFFF, PM, 1'b1, 8'hFF);
    vecs[5] = mk(2'd2, 4'h7, 8'h12, 8'h00, 32'h37373737,  1, 1'b0, 8'h37);
`else
    vecs[2] = mk(2'd2, 4'h5, 8'h00, 8'h01, 32'h00010101, -1, 1'b1, 8'h00);
    vecs[3] = mk(2'd2, 4'h5, 8'h00, 8'hFF, 32'hFFFFFFFF, -1, 1'b1, 8'h00);
    vecs[5] = mk(2'd2, 4'h7, 8'h12, 8'h00, 32'h37373737, -1, 1'b1, 8'h00);
`endif
    vecs[4] = mk(2'd3, 4'h2, 8'h33, 8'h00, 32'h0,        -1, 1'b1, 8'h00);
    vecs[6] = mk(2'd0, 4'hF, 8'hA5, 8'h00, 32'h0,         0, 1'b0, 8'h00);
    vecs[7] = mk(2'd1, 4'h0, 8'h00, 8'h00, 32'hC3C3C3C3,  1, 1'b0, 8'hC3);

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("after_release");

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i], 1'b0, 1'b1);
      drain();
    end

    // Back-to-back with cmd_valid held: write, read, then reserved op.
    drive(mk(2'd0, 4'h3, 8'h81, 8'h00, 32'h0, 0, 1'b0, 8'h00), 1'b1, 1'b1);
    drive(mk(2'd1, 4'h9, 8'h00, 8'h00, 32'h6E6E6E6E, 1, 1'b0, 8'h6E), 1'b1, 1'b1);
    drive(mk(2'd3, 4'h4, 8'h00, 8'h00, 32'h0, -1, 1'b1, 8'h00), 1'b0, 1'b1);
    drain();

    // Reset during the read strobe must drop the bus asynchronously and suppress the response.
    drive(mk(2'd1, 4'h6, 8'h00, 8'h00, 32'h99999999, 1, 1'b0, 8'h99), 1'b0, 1'b0);
    budget = 50;
    while (bus_rd_n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("reset_test_read_strobe_seen", bus_rd_n, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_cs_n", bus_cs_n, 1);
    chk("async_reset_rd_n", bus_rd_n, 1);
    chk("async_reset_wr_n", bus_wr_n, 1);
    chk("async_reset_rsp_valid", rsp_valid, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1);
    repeat (3) @(negedge clk);

    drive(vecs[1], 1'b0, 1'b1);
    drain();
    chk("final_protocol_violations", bad_proto, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached required=finish");
    $fatal(1, "simulation timeout");
  end

endmodule
